// File: rtl/expr_pipe_unit.sv
// Two-stage multi-lane expression unit: S1 registers the operand bundle, S2 computes
// per-lane results (including per-lane accumulators) and holds them under backpressure.
module expr_pipe_unit #(
    parameter int unsigned W     = 6,
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y,
    output logic               err
);

    localparam int unsigned BW     = LANES * W;
    localparam int unsigned SW     = $clog2(W) + 1;
    localparam logic [3:0]  OP_ACC = 4'd10;

    logic          r_rdy_en;
    logic          r_s1_valid;
    logic [3:0]    r_op;
    logic          r_sign_a;
    logic          r_sign_b;
    logic [BW-1:0] r_a;
    logic [BW-1:0] r_b;
    logic          r_out_valid;
    logic [BW-1:0] r_y;
    logic          r_err;

    logic          w_advance;
    logic          w_accept;
    logic          w_signed;
    logic          w_err;
    logic          w_acc_upd;
    logic [BW-1:0] w_res;

    // r_rdy_en keeps in_ready low during reset and until the first clock after release
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = r_rdy_en && (!r_s1_valid || w_advance);
    assign w_accept  = in_valid && in_ready;
    assign w_signed  = r_sign_a && r_sign_b;
    assign w_err     = (r_op > OP_ACC);
    assign w_acc_upd = w_advance && r_s1_valid && (r_op == OP_ACC);

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign err       = r_err;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W-1:0]  w_la;
        logic [W-1:0]  w_lb;
        logic [W-1:0]  w_lres;
        logic [W-1:0]  w_acc_base;
        logic [W-1:0]  w_acc_sum;
        logic [W-1:0]  r_acc;
        logic [SW-1:0] w_sh;
        logic          w_sh_big;
        logic          w_fill;

        assign w_la       = r_a[g*W +: W];
        assign w_lb       = r_b[g*W +: W];
        assign w_sh       = w_lb[SW-1:0];
        assign w_sh_big   = (w_sh >= SW'(W));
        assign w_fill     = r_sign_a && w_la[W-1];
        // Sign- vs zero-extension of a is invisible in a W-bit wrapping sum
        assign w_acc_base = acc_clr ? '0 : r_acc;
        assign w_acc_sum  = w_acc_base + w_la;

        always_comb begin
            w_lres = '0;
            case (r_op)
                4'd0:    w_lres = w_la + w_lb;
                4'd1:    w_lres = w_la - w_lb;
                4'd2:    w_lres = w_la & w_lb;
                4'd3:    w_lres = ~(w_la ^ w_lb);
                4'd4:    w_lres = W'(w_signed ? ($signed(w_la) < $signed(w_lb)) : (w_la < w_lb));
                4'd5:    w_lres = w_sh_big ? '0 : (w_la << w_sh);
                4'd6: begin
                    // Oversized shifts saturate to the fill value
                    if (w_sh_big)      w_lres = {W{w_fill}};
                    else if (r_sign_a) w_lres = W'($signed(w_la) >>> w_sh);
                    else               w_lres = w_la >> w_sh;
                end
                4'd7:    w_lres = W'(w_la != w_lb);
                4'd8:    w_lres = W'(~^w_la);
                4'd9:    w_lres = (w_lb != '0) ? w_la : ~w_la;
                4'd10:   w_lres = w_acc_sum;
                default: w_lres = '0;
            endcase
        end

        assign w_res[g*W +: W] = w_lres;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_acc_upd) begin
                r_acc <= w_acc_sum;
            end else if (acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    // S1 operand capture and S2 result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en    <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_op        <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_op       <= op;
                r_sign_a   <= sign_a;
                r_sign_b   <= sign_b;
                r_a        <= a;
                r_b        <= b;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
            if (w_advance) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_y   <= w_res;
                    r_err <= w_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_expr_pipe_unit.sv
// Bench for expr_pipe_unit (W=6, LANES=4): directed vector table, multi-cycle
// sequences, and randomized traffic against an arithmetic reference model.
module tb_expr_pipe_unit;

    localparam int unsigned W     = 6;
    localparam int unsigned LANES = 4;
    localparam int unsigned BW    = W * LANES;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic          sign_a;
    logic          sign_b;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] y;
    logic          err;

    expr_pipe_unit #(.W(W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sign_a(sign_a), .sign_b(sign_b), .a(a), .b(b),
        .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string         name;
        logic [3:0]    op;
        logic          sa;
        logic          sb;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] y;
        logic          err;
    } vec_t;

    typedef struct {
        logic [BW-1:0] y;
        logic          err;
    } exp_t;

    vec_t tv[$];
    exp_t sb_q[$];
    int   m_acc[LANES];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [3:0] t_op, input logic t_sa, input logic t_sb,
                           input logic [BW-1:0] t_a, input logic [BW-1:0] t_b,
                           input logic [BW-1:0] e_y, input logic e_err);
        vec_t v;
        v.name = nm; v.op = t_op; v.sa = t_sa; v.sb = t_sb;
        v.a = t_a; v.b = t_b; v.y = e_y; v.err = e_err;
        tv.push_back(v);
    endtask

    // Reference model: plain integer arithmetic on each lane, accumulators as an int array
    function automatic void ref_bundle(input logic [3:0] f_op, input logic f_sa, input logic f_sb,
                                       input logic [BW-1:0] f_a, input logic [BW-1:0] f_b,
                                       output logic [BW-1:0] f_y, output logic f_err);
        int mask;
        int ua, ub, sva, svb, sh, r;
        mask  = (1 << W) - 1;
        f_err = (f_op > 4'd10);
        f_y   = '0;
        for (int l = 0; l < LANES; l++) begin
            ua  = int'(f_a[l*W +: W]);
            ub  = int'(f_b[l*W +: W]);
            sva = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
            svb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
            sh  = ub % (1 << ($clog2(W) + 1));
            case (f_op)
                4'd0:    r = (ua + ub) & mask;
                4'd1:    r = (ua - ub) & mask;
                4'd2:    r = ua & ub;
                4'd3:    r = ~(ua ^ ub) & mask;
                4'd4:    r = (f_sa && f_sb) ? ((sva < svb) ? 1 : 0) : ((ua < ub) ? 1 : 0);
                4'd5:    r = (sh >= W) ? 0 : ((ua << sh) & mask);
                4'd6:    r = f_sa ? ((sva >>> sh) & mask) : (ua >> sh);
                4'd7:    r = (ua != ub) ? 1 : 0;
                4'd8:    r = ($countones(ua) % 2 == 0) ? 1 : 0;
                4'd9:    r = (ub != 0) ? ua : (~ua & mask);
                4'd10: begin
                    m_acc[l] = (m_acc[l] + (f_sa ? sva : ua)) & mask;
                    r = m_acc[l];
                end
                default: r = 0;
            endcase
            f_y[l*W +: W] = r[W-1:0];
        end
    endfunction

    // Single bundle through an idle pipe; optional acc_clr in the cycle it advances to S2
    task automatic run_one(input string nm, input logic [3:0] t_op, input logic t_sa, input logic t_sb,
                           input logic [BW-1:0] t_a, input logic [BW-1:0] t_b, input logic t_clr,
                           input logic [BW-1:0] e_y, input logic e_err);
        logic acc_ok;
        acc_ok    = 1'b0;
        op        = t_op; sign_a = t_sa; sign_b = t_sb; a = t_a; b = t_b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_accept"}, 64'(acc_ok), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_clr  = t_clr;
        @(negedge clk);
        chk({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        acc_clr = 1'b0;
        @(negedge clk);
        chk({nm, "_lat2_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_y"}, 64'(y), 64'(e_y));
        chk({nm, "_err"}, 64'(err), 64'(e_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] e_y;
        logic          e_err;
        exp_t          e;
        logic          held_v;
        logic [BW-1:0] held_y;
        logic          held_err;
        int            k, nout;
        logic          dropped;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; sign_a = 1'b0; sign_b = 1'b0;
        a = '0; b = '0; acc_clr = 1'b0; out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors: lane 3 first in each concatenation, lane 0 last
        add_vec("add_wrap", 4'd0, 1'b0, 1'b0, {6'd3, 6'd10, 6'd0, 6'd63}, {6'd4, 6'd60, 6'd0, 6'd1},
                {6'd7, 6'd6, 6'd0, 6'd0}, 1'b0);
        add_vec("sub", 4'd1, 1'b0, 1'b0, {6'd5, 6'd0, 6'd10, 6'd1}, {6'd3, 6'd1, 6'd4, 6'd2},
                {6'd2, 6'd63, 6'd6, 6'd63}, 1'b0);
        add_vec("lt_signed", 4'd4, 1'b1, 1'b1, {6'd1, 6'd0, 6'h20, 6'h3F}, {6'h3F, 6'd0, 6'd1, 6'd1},
                {6'd0, 6'd0, 6'd1, 6'd1}, 1'b0);
        add_vec("lt_mixed_unsigned", 4'd4, 1'b1, 1'b0, {6'd1, 6'd0, 6'h20, 6'h3F}, {6'h3F, 6'd0, 6'd1, 6'd1},
                {6'd1, 6'd0, 6'd0, 6'd0}, 1'b0);
        add_vec("asr_signed", 4'd6, 1'b1, 1'b0, {6'h3F, 6'h10, 6'h20, 6'h20}, {6'd5, 6'd1, 6'd0, 6'd2},
                {6'h3F, 6'h08, 6'h20, 6'h38}, 1'b0);
        add_vec("asr_unsigned", 4'd6, 1'b0, 1'b0, {6'h3F, 6'h10, 6'h20, 6'h20}, {6'd5, 6'd1, 6'd0, 6'd2},
                {6'h01, 6'h08, 6'h20, 6'h08}, 1'b0);
        add_vec("shl_range", 4'd5, 1'b0, 1'b0, {6'h3F, 6'd1, 6'd3, 6'd1}, {6'd6, 6'd5, 6'h11, 6'd15},
                {6'd0, 6'h20, 6'd6, 6'd0}, 1'b0);
        add_vec("and", 4'd2, 1'b0, 1'b0, {6'h3F, 6'h2A, 6'h0F, 6'h33}, {6'h15, 6'h3F, 6'h3C, 6'h0F},
                {6'h15, 6'h2A, 6'h0C, 6'h03}, 1'b0);
        add_vec("xnor", 4'd3, 1'b0, 1'b0, {6'h00, 6'h3F, 6'h2A, 6'h15}, {6'h00, 6'h00, 6'h15, 6'h15},
                {6'h3F, 6'h00, 6'h00, 6'h3F}, 1'b0);
        add_vec("case_ne", 4'd7, 1'b0, 1'b0, {6'd5, 6'd5, 6'd0, 6'd1}, {6'd5, 6'd4, 6'd0, 6'd1},
                {6'd0, 6'd1, 6'd0, 6'd0}, 1'b0);
        add_vec("red_xnor", 4'd8, 1'b0, 1'b0, {6'h3F, 6'h01, 6'h03, 6'h00}, '0,
                {6'd1, 6'd0, 6'd1, 6'd1}, 1'b0);
        add_vec("sel_inv", 4'd9, 1'b0, 1'b0, {6'h2A, 6'h2A, 6'h01, 6'h01}, {6'h20, 6'h00, 6'h00, 6'h01},
                {6'h2A, 6'h15, 6'h3E, 6'h01}, 1'b0);
        add_vec("illegal_11", 4'd11, 1'b1, 1'b1, {4{6'h15}}, {4{6'h2A}}, '0, 1'b1);
        add_vec("illegal_12", 4'd12, 1'b0, 1'b0, {4{6'h15}}, {4{6'h2A}}, '0, 1'b1);
        add_vec("illegal_15", 4'd15, 1'b0, 1'b1, {4{6'h3F}}, {4{6'h3F}}, '0, 1'b1);

        foreach (tv[i])
            run_one(tv[i].name, tv[i].op, tv[i].sa, tv[i].sb, tv[i].a, tv[i].b, 1'b0, tv[i].y, tv[i].err);

        // Accumulator sequence, including a clear coinciding with an accumulate
        run_one("acc1", 4'd10, 1'b1, 1'b0, {6'd1, 6'd2, 6'd7, 6'd5}, '0, 1'b0, {6'd1, 6'd2, 6'd7, 6'd5}, 1'b0);
        run_one("acc2", 4'd10, 1'b1, 1'b0, {4{6'h3E}}, '0, 1'b0, {6'd63, 6'd0, 6'd5, 6'd3}, 1'b0);
        run_one("acc3_clr", 4'd10, 1'b1, 1'b0, {4{6'd1}}, '0, 1'b1, {4{6'd1}}, 1'b0);
        run_one("acc4", 4'd10, 1'b0, 1'b0, {4{6'd2}}, '0, 1'b0, {4{6'd3}}, 1'b0);
        run_one("acc_keep_add", 4'd0, 1'b0, 1'b0, {4{6'd1}}, {4{6'd1}}, 1'b0, {4{6'd2}}, 1'b0);
        run_one("acc5", 4'd10, 1'b0, 1'b0, '0, '0, 1'b0, {4{6'd3}}, 1'b0);

        // Backpressure: four back-to-back bundles with out_ready low for three cycles
        k = 0; nout = 0; dropped = 1'b0; held_v = 1'b0; held_y = '0; held_err = 1'b0;
        for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
            in_valid  = (k < 4);
            op        = 4'd0; sign_a = 1'b0; sign_b = 1'b0; b = '0;
            a         = {4{6'(k * 3 + 1)}};
            out_ready = !(cyc >= 1 && cyc <= 3);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    chk("bp_y_stable", 64'(y), 64'(held_y));
                    chk("bp_err_stable", 64'(err), 64'(held_err));
                end
                held_v = 1'b1; held_y = y; held_err = err;
            end else if (out_valid && out_ready) begin
                chk("bp_order_y", 64'(y), 64'({4{6'(nout * 3 + 1)}}));
                nout++;
                held_v = 1'b0;
            end
            if (!in_ready && !dropped) begin
                dropped = 1'b1;
                chk("bp_accepted_before_drop", 64'(k), 64'd2);
            end
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_all_out", 64'(nout), 64'd4);
        chk("bp_drop_seen", 64'(dropped), 64'd1);

        // Reset with two bundles in flight
        out_ready = 1'b0; op = 4'd0; a = {4{6'd9}}; b = {4{6'd1}}; in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_flight_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_y", 64'(y), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_release_in_ready", 64'(in_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("mid_no_stale", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model
        foreach (m_acc[i]) m_acc[i] = 0;
        held_v = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 4'($urandom_range(0, 15));
            sign_a    = 1'($urandom);
            sign_b    = 1'($urandom);
            a         = BW'($urandom);
            b         = BW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (held_v) begin
                chk("rand_y_stable", 64'(y), 64'(held_y));
                chk("rand_err_stable", 64'(err), 64'(held_err));
                held_v = 1'b0;
            end
            if (out_valid && !out_ready) begin
                held_v = 1'b1; held_y = y; held_err = err;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rand_unexpected_output: got y=%0h with empty scoreboard", y);
                end else begin
                    e = sb_q.pop_front();
                    chk("rand_y", 64'(y), 64'(e.y));
                    chk("rand_err", 64'(err), 64'(e.err));
                end
            end
            if (in_valid && in_ready) begin
                ref_bundle(op, sign_a, sign_b, a, b, e_y, e_err);
                e.y = e_y; e.err = e_err;
                sb_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb_q.pop_front();
                chk("drain_y", 64'(y), 64'(e.y));
                chk("drain_err", 64'(err), 64'(e.err));
            end
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/expr_pipe_unit.md
EXPR_PIPE_UNIT -- requirements
Module: expr_pipe_unit

Interface
REQ-001 SHALL have parameter W, default 6: operand and result width per lane, legal range 2..32.
REQ-002 SHALL have parameter LANES, default 4: number of independent lanes, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand bundle valid.
REQ-006 SHALL have port in_ready, output, 1 bit: unit can accept a bundle this cycle.
REQ-007 SHALL have port op, input, 4 bits: operation code, shared by all lanes.
REQ-008 SHALL have ports sign_a and sign_b, input, 1 bit each: operand A/B signedness.
REQ-009 SHALL have ports a and b, input, LANES*W bits each: lane i occupies [i*W +: W].
REQ-010 SHALL have port acc_clr, input, 1 bit: synchronous accumulator clear.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 SHALL have port y, output, LANES*W bits: lane results, same packing as a.
REQ-014 SHALL have port err, output, 1 bit: result came from an illegal op.

Function
REQ-015 SHALL accept a bundle iff in_valid && in_ready; SHALL return a result iff out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline: S1 registers op/sign/a/b; S2 computes and registers y/err; latency exactly 2 cycles when out_ready held high.
REQ-017 SHALL advance when S2 is empty or out_ready=1; in_ready = !S1_valid || advance, with no combinational path from in_valid to in_ready.
REQ-018 SHALL sustain one bundle per cycle with out_ready=1; with out_ready=0, SHALL hold y/err stable and buffer up to 2 bundles without loss.
REQ-019 SHALL treat a comparison or arithmetic op as signed only when sign_a && sign_b; otherwise both operands unsigned.
REQ-020 SHALL implement ops per lane with W-bit wrap: 0 add; 1 sub; 2 AND; 3 XNOR (~^); 4 a<b zero-extended to W; 5 a<<b[low clog2(W)+1 bits], values >=W give 0; 6 a>>>b, sign-filling only when sign_a=1, shift amount as op 5; 7 a!==b zero-extended; 8 reduction XNOR of a zero-extended; 9 (b!=0)?a:~a; 10 accumulate.
REQ-021 SHALL for op 10 add lane a, sign-extended when sign_a=1 and zero-extended otherwise, into a per-lane W-bit wrapping accumulator at S2 advance; y = updated accumulator.
REQ-022 SHALL, when acc_clr=1, clear all accumulators in the same cycle; an op-10 bundle advancing in that cycle SHALL see 0 as the prior value.
REQ-023 SHALL for ops 11..15 output y=0 and err=1; err=0 for legal ops.
REQ-024 SHALL leave accumulators unchanged by non-accumulate ops and stalls.

Reset
REQ-025 SHALL, on rst_n low, immediately clear S1/S2 valid, y=0, err=0, out_valid=0, in_ready=0 while in reset, all accumulators=0.
REQ-026 SHALL discard in-flight bundles on reset mid-operation; in_ready=1 on the first clock after rst_n deasserts.

Verification (W=6, LANES=4)
REQ-027 Add wrap: lane0 a=63, b=1, op=0 -> lane0 y=0, out_valid 2 cycles after accept.
REQ-028 Signedness: a=6'h3F, b=1, op=4; sign_a=sign_b=1 -> y=1; sign_a=1, sign_b=0 -> y=0.
REQ-029 Arithmetic shift: a=6'h20, b=2, op=6; sign_a=1 -> y=6'h38; sign_a=0 -> y=6'h08.
REQ-030 Backpressure: 4 back-to-back bundles, out_ready low 3 cycles -> in_ready drops after 2 accepted, no loss, in-order outputs, y stable while stalled.
REQ-031 Accumulate: op=10 sign_a=1 a=5, then a=6'h3E(-2) -> y=5 then y=3; acc_clr with third a=1 -> y=1.
REQ-032 Reset mid-flight and illegal op: op=12 -> y=0, err=1; rst_n low with 2 bundles in flight -> out_valid=0 at once, no stale result after release.
